prefetch_queue: RTL and testbench

Instruction prefetch queue for the NEC core. It fetches code words from the bus interface at PS:PC and holds them in a byte queue. The pre-decoder sits directly downstream: it reads a window of the next bytes, builds a `pre_decode_t`, and pops `pre_size` bytes per instruction. Branches, calls, returns and interrupts discard the queue and restart fetching at a new PS:PC through a flush.

---
 rtl/types.sv | 18 +
 rtl/prefetch_ring.sv | 50 +++++
 rtl/prefetch_queue.sv | 122 ++++++++++++
 tb/tb_prefetch_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/types.sv
// Shared types and reset constants for the instruction prefetch queue.
package types;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DISCARD
  } fetch_state_e;

  localparam logic [15:0] RESET_PS = 16'hFFFF;
  localparam logic [15:0] RESET_PC = 16'h0000;

  // Physical address of seg:off, wrapping modulo 2^20.
  function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

endpackage

// File: rtl/prefetch_ring.sv
// Byte ring buffer: 0-2 byte append, 0-15 byte pop, combinational read window.
module prefetch_ring #(
  parameter int unsigned QUEUE_BYTES  = 8,
  parameter int unsigned WINDOW_BYTES = 6,
  localparam int unsigned PTR_W = $clog2(QUEUE_BYTES),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic [1:0]                wr_n,
  input  logic [15:0]               wr_data,
  input  logic [3:0]                pop_n,
  output logic [8*WINDOW_BYTES-1:0] window,
  output logic [CNT_W-1:0]          count
);

  logic [7:0]       mem_q [QUEUE_BYTES];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  // New bytes land behind the current contents; popped bytes come off the head.
  assign wr_ptr = rd_q + count_q[PTR_W-1:0];
  assign count  = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QUEUE_BYTES; i++) mem_q[i] <= 8'h00;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      if (wr_n != 2'd0) mem_q[wr_ptr] <= wr_data[7:0];
      if (wr_n == 2'd2) mem_q[wr_ptr + PTR_W'(1)] <= wr_data[15:8];
      rd_q    <= rd_q + PTR_W'(pop_n);
      count_q <= count_q - CNT_W'(pop_n) + CNT_W'(wr_n);
    end
  end

  // Bytes beyond the valid count read as zero.
  always_comb begin
    window = '0;
    for (int i = 0; i < WINDOW_BYTES; i++) begin
      if (i < int'(count_q)) window[8*i +: 8] = mem_q[rd_q + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetch FSM, PS:PC address arithmetic and flush handling.
module prefetch_queue
  import types::*;
#(
  parameter int unsigned QUEUE_BYTES  = 8,
  parameter int unsigned WINDOW_BYTES = 6
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [15:0]               flush_ps,
  input  logic [15:0]               flush_pc,
  output logic                      fetch_req,
  output logic [19:0]               fetch_addr,
  input  logic                      fetch_ack,
  input  logic [15:0]               fetch_data,
  output logic [8*WINDOW_BYTES-1:0] window,
  output logic [3:0]                window_count,
  input  logic                      consume,
  input  logic [3:0]                consume_size,
  output logic [15:0]               pc,
  output logic [15:0]               ps
);

  localparam int unsigned CNT_W = $clog2(QUEUE_BYTES) + 1;

  fetch_state_e     state_q, state_n;
  logic [15:0]      ps_q, ps_n, pc_q, pc_n, fpc_q, fpc_n;
  logic [19:0]      addr_q, addr_n;
  logic             req_q, req_n;
  logic             pop_ok;
  logic [31:0]      free_after, need;
  logic [1:0]       wr_n;
  logic [15:0]      wr_data;
  logic [3:0]       pop_n;
  logic [CNT_W-1:0] ring_count;

  prefetch_ring #(
    .QUEUE_BYTES (QUEUE_BYTES),
    .WINDOW_BYTES(WINDOW_BYTES)
  ) u_ring (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (flush),
    .wr_n   (wr_n),
    .wr_data(wr_data),
    .pop_n  (pop_n),
    .window (window),
    .count  (ring_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH_IDLE;
      ps_q    <= RESET_PS;
      pc_q    <= RESET_PC;
      fpc_q   <= RESET_PC;
      addr_q  <= phys_addr(RESET_PS, RESET_PC);
      req_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      ps_q    <= ps_n;
      pc_q    <= pc_n;
      fpc_q   <= fpc_n;
      addr_q  <= addr_n;
      req_q   <= req_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    ps_n       = ps_q;
    pc_n       = pc_q;
    fpc_n      = fpc_q;
    addr_n     = addr_q;
    wr_n       = 2'd0;
    pop_n      = 4'd0;
    wr_data    = fpc_q[0] ? {8'h00, fetch_data[15:8]} : fetch_data;
    pop_ok     = consume && !flush && (32'(consume_size) <= 32'(ring_count));
    if (pop_ok) begin
      pop_n = consume_size;
      pc_n  = pc_q + 16'(consume_size);
    end
    free_after = 32'(QUEUE_BYTES) - 32'(ring_count) + 32'(pop_n);
    need       = fpc_q[0] ? 32'd1 : 32'd2;
    if (flush) begin
      ps_n  = flush_ps;
      pc_n  = flush_pc;
      fpc_n = flush_pc;
    end
    case (state_q)
      FETCH_IDLE: begin
        if (flush || free_after >= need) state_n = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (fetch_ack) begin
          state_n = FETCH_IDLE;
          if (!flush) begin
            wr_n  = fpc_q[0] ? 2'd1 : 2'd2;
            fpc_n = fpc_q + 16'(wr_n);
          end
        end else if (flush) begin
          state_n = FETCH_DISCARD;
        end
      end
      FETCH_DISCARD: begin
        if (fetch_ack) state_n = FETCH_IDLE;
      end
      default: state_n = FETCH_IDLE;
    endcase
    // The bus address is frozen for the whole life of an outstanding request.
    if (state_q == FETCH_IDLE || state_n == FETCH_IDLE) addr_n = phys_addr(ps_n, fpc_n);
    req_n = (state_n != FETCH_IDLE);
  end

  assign fetch_req    = req_q;
  assign fetch_addr   = addr_q;
  assign pc           = pc_q;
  assign ps           = ps_q;
  assign window_count = (32'(ring_count) < 32'(WINDOW_BYTES)) ? 4'(ring_count) : 4'(WINDOW_BYTES);

endmodule

// File: tb/tb_prefetch_queue.sv
// Prefetch queue bench: directed scenarios plus random traffic against a byte-queue model.
module tb_prefetch_queue;

  localparam int QB = 8;
  localparam int WB = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic [15:0]   flush_ps, flush_pc;
  logic          fetch_req;
  logic [19:0]   fetch_addr;
  logic          fetch_ack;
  logic [15:0]   fetch_data;
  logic [8*WB-1:0] window;
  logic [3:0]    window_count;
  logic          consume;
  logic [3:0]    consume_size;
  logic [15:0]   pc, ps;

  int checks = 0;
  int failures = 0;

  // Reference model: a byte queue plus "request outstanding" / "data stale" flags.
  logic [7:0]  mq[$];
  logic [15:0] m_ps, m_pc, m_fpc;
  logic [19:0] m_addr;
  bit          m_out, m_stale;

  prefetch_queue #(.QUEUE_BYTES(QB), .WINDOW_BYTES(WB)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .flush_ps(flush_ps), .flush_pc(flush_pc),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .window(window), .window_count(window_count), .consume(consume), .consume_size(consume_size),
    .pc(pc), .ps(ps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] phys(input logic [15:0] s, input logic [15:0] o);
    return 20'({s, 4'h0} + {4'h0, o});
  endfunction

  function automatic logic [8*WB-1:0] exp_window();
    logic [8*WB-1:0] w = '0;
    for (int i = 0; i < WB; i++) if (i < mq.size()) w[8*i +: 8] = mq[i];
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ps = 16'hFFFF; m_pc = 16'h0; m_fpc = 16'h0;
    m_addr = 20'h0; m_out = 0; m_stale = 0;
  endtask

  task automatic model_step();
    bit pop_ok, ack_live;
    int need;
    pop_ok   = !flush && consume && (int'(consume_size) <= mq.size());
    ack_live = m_out && !m_stale && fetch_ack && !flush;
    if (pop_ok) begin
      repeat (int'(consume_size)) void'(mq.pop_front());
      m_pc = m_pc + 16'(consume_size);
    end
    if (ack_live) begin
      if (m_fpc[0]) begin
        mq.push_back(fetch_data[15:8]);
        m_fpc = m_fpc + 16'd1;
      end else begin
        mq.push_back(fetch_data[7:0]);
        mq.push_back(fetch_data[15:8]);
        m_fpc = m_fpc + 16'd2;
      end
    end
    if (flush) begin
      mq.delete();
      m_ps = flush_ps; m_pc = flush_pc; m_fpc = flush_pc;
    end
    if (m_out) begin
      if (fetch_ack) begin
        m_out = 0; m_stale = 0;
      end else if (flush) begin
        m_stale = 1;
      end
    end else begin
      need = m_fpc[0] ? 1 : 2;
      if (flush || (QB - mq.size()) >= need) begin
        m_out = 1;
        m_addr = phys(m_ps, m_fpc);
      end
    end
  endtask

  task automatic compare_all();
    int wc;
    wc = (mq.size() < WB) ? mq.size() : WB;
    chk("fetch_req", 64'(fetch_req), 64'(m_out));
    chk("fetch_addr", 64'(fetch_addr), 64'(m_out ? m_addr : phys(m_ps, m_fpc)));
    chk("ps", 64'(ps), 64'(m_ps));
    chk("pc", 64'(pc), 64'(m_pc));
    chk("window_count", 64'(window_count), 64'(wc));
    chk("window", 64'(window), 64'(exp_window()));
  endtask

  task automatic cycle(input logic f, input logic [15:0] fps, input logic [15:0] fpc,
                       input logic a, input logic [15:0] d, input logic c, input logic [3:0] sz);
    flush = f; flush_ps = fps; flush_pc = fpc;
    fetch_ack = a; fetch_data = d; consume = c; consume_size = sz;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int n;
    logic a;
    reset_n = 1'b0;
    flush = 0; flush_ps = 0; flush_pc = 0; fetch_ack = 0; fetch_data = 0; consume = 0; consume_size = 0;
    model_reset();
    @(negedge clk);
    chk("rst_req", 64'(fetch_req), 64'd0);
    chk("rst_addr", 64'(fetch_addr), 64'hFFFF0);
    chk("rst_ps", 64'(ps), 64'hFFFF);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_wc", 64'(window_count), 64'd0);
    chk("rst_window", 64'(window), 64'd0);
    reset_n = 1'b1;

    // Fill from reset, acking every request.
    n = 0;
    for (int k = 0; k < 14; k++) begin
      a = m_out;
      if (a) chk("fill_addr", 64'(fetch_addr), 64'(20'hFFFF0 + 20'(2 * n)));
      cycle(0, 16'h0, 16'h0, a, 16'(16'h1100 + n), 0, 4'd0);
      if (a) n++;
    end
    chk("fill_words", 64'(n), 64'd4);
    chk("full_wc", 64'(window_count), 64'd6);
    chk("full_no_req", 64'(fetch_req), 64'd0);
    chk("full_window", 64'(window), 64'h110211011100);

    // Pop 2 to open space, then ack and pop 3 in the same cycle.
    cycle(0, 16'h0, 16'h0, 0, 16'h0, 1, 4'd2);
    chk("ca_addr", 64'(fetch_addr), 64'hFFFF8);
    cycle(0, 16'h0, 16'h0, 1, 16'h1104, 1, 4'd3);
    chk("ca_pc", 64'(pc), 64'd5);
    chk("ca_wc", 64'(window_count), 64'd5);
    chk("ca_window", 64'(window), 64'h001104110311);

    // Odd flush target: only the high byte is queued.
    cycle(1, 16'h0000, 16'h0003, 0, 16'h0, 0, 4'd0);
    chk("oflush_addr", 64'(fetch_addr), 64'h00003);
    chk("oflush_wc", 64'(window_count), 64'd0);
    cycle(0, 16'h0, 16'h0, 1, 16'hAABB, 0, 4'd0);
    chk("odd_window", 64'(window), 64'hAA);
    chk("odd_pc", 64'(pc), 64'd3);
    chk("odd_next_addr", 64'(fetch_addr), 64'h00004);
    cycle(0, 16'h0, 16'h0, 0, 16'h0, 0, 4'd0);
    chk("odd_req", 64'(fetch_req), 64'd1);

    // Flush while a request is outstanding: its data must be dropped.
    cycle(1, 16'h1234, 16'h0010, 0, 16'h0, 0, 4'd0);
    chk("disc_req", 64'(fetch_req), 64'd1);
    chk("disc_addr_hold", 64'(fetch_addr), 64'h00004);
    cycle(0, 16'h0, 16'h0, 0, 16'h0, 0, 4'd0);
    cycle(0, 16'h0, 16'h0, 1, 16'hDEAD, 0, 4'd0);
    chk("dead_wc", 64'(window_count), 64'd0);
    cycle(0, 16'h0, 16'h0, 0, 16'h0, 0, 4'd0);
    chk("reflush_addr", 64'(fetch_addr), 64'h12350);
    cycle(0, 16'h0, 16'h0, 1, 16'h5566, 0, 4'd0);
    chk("after_dead_window", 64'(window), 64'h5566);

    // Oversize consume is ignored.
    cycle(0, 16'h0, 16'h0, 0, 16'h0, 1, 4'd4);
    chk("oversize_pc", 64'(pc), 64'h0010);
    chk("oversize_wc", 64'(window_count), 64'd2);
    cycle(0, 16'h0, 16'h0, 1, 16'h0000, 0, 4'd0);

    // Fetch offset wraps without touching the segment.
    cycle(1, 16'h2000, 16'hFFFE, 0, 16'h0, 0, 4'd0);
    chk("wrap_req_addr", 64'(fetch_addr), 64'h2FFFE);
    cycle(0, 16'h0, 16'h0, 1, 16'h7788, 0, 4'd0);
    chk("wrap_addr", 64'(fetch_addr), 64'h20000);
    chk("wrap_ps", 64'(ps), 64'h2000);
    chk("wrap_window", 64'(window), 64'h7788);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 31) == 0), 16'($urandom), 16'($urandom),
            m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0),
            16'($urandom), ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 7)));
    end

    // Reset while a request is outstanding.
    cycle(1, 16'h4321, 16'h0101, 0, 16'h0, 0, 4'd0);
    chk("pre_rst_req", 64'(fetch_req), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(fetch_req), 64'd0);
    chk("mid_rst_addr", 64'(fetch_addr), 64'hFFFF0);
    chk("mid_rst_ps", 64'(ps), 64'hFFFF);
    chk("mid_rst_pc", 64'(pc), 64'd0);
    chk("mid_rst_wc", 64'(window_count), 64'd0);
    chk("mid_rst_window", 64'(window), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle(0, 16'h0, 16'h0, m_out, 16'($urandom), ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
